// File: rtl/bytelink_mem_target_if.sv
// Purpose: link and memory-port signal bundle for bytelink_mem_target.
// Latency: none, wires only.
// Backpressure: the link side has none; the memory side stalls through mem_ready.
interface bytelink_mem_target_if #(
    parameter int ADDR_W = 32
);
    // Byte-serial link from the CPU-side handler
    logic              lk_start;
    logic              lk_rw;
    logic [7:0]        lk_addr;
    logic [7:0]        lk_wdata;
    logic [7:0]        lk_rdata;
    logic              lk_rvalid;
    logic              lk_err;
    logic              lk_overrun;

    // Single-beat local memory port
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    // Environment view: CPU link handler plus SRAM/peripheral decode
    modport master (
        output lk_start, lk_rw, lk_addr, lk_wdata, mem_rdata, mem_ready,
        input  lk_rdata, lk_rvalid, lk_err, lk_overrun,
        input  mem_addr, mem_wdata, mem_we, mem_re
    );

    // Target view: the memory-side endpoint itself
    modport slave (
        input  lk_start, lk_rw, lk_addr, lk_wdata, mem_rdata, mem_ready,
        output lk_rdata, lk_rvalid, lk_err, lk_overrun,
        output mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/bytelink_mem_target.sv
// Purpose: memory-side endpoint of the byte-serial link; gathers a 4-beat request, does one memory access, returns 4 response bytes.
// Latency: request at S+4, first response byte at R+1 (min 5 cycles after beat 0, 9-cycle frame); optional timeout via BYTELINK_TIMEOUT_EN.
// Backpressure: none toward the link (early lk_start is dropped and flagged in sticky lk_overrun); memory stalls via mem_ready.
module bytelink_mem_target #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bytelink_mem_target_if.slave  bus
);

    // Elaboration-time parameter sanity
    if (ADDR_W < 1 || ADDR_W > 32) begin : g_bad_addr_w
        $error("bytelink_mem_target: ADDR_W must be 1..32");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("bytelink_mem_target: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        MEM     = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Everything captured from the link for one request
    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } frame_t;

    state_t      state_q;
    state_t      state_nxt;
    logic [1:0]  beat_q;        // beat index in COLLECT (1..3) and RESP (0..3)
    frame_t      frame_q;
    logic [23:0] resp_sh_q;     // response bytes 1..3 still to be sent
    logic [7:0]  lk_rdata_q;
    logic        lk_rvalid_q;
    logic        lk_overrun_q;
    logic        mem_we_q;
    logic        mem_re_q;

    logic        done;          // MEM finishes this cycle (ready or timeout)
    logic        timeout;
    logic        cap_en;
    logic [1:0]  cap_idx;
    logic        mem_we_nxt;
    logic        mem_re_nxt;
    logic        rvalid_nxt;
    logic [31:0] resp_word;

`ifdef BYTELINK_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt_q;
    logic        lk_err_q;

    // Cycles spent in MEM; zero whenever outside MEM so every entry starts at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 16'd0;
        end else if (state_q != MEM) begin
            tmo_cnt_q <= 16'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // Give up only on the last permitted cycle if memory still is not ready
    assign timeout = (state_q == MEM) && !bus.mem_ready && (tmo_cnt_q == TMO_LAST);

    // Error flag follows the response it belongs to and clears as RESP ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_err_q <= 1'b0;
        end else if (done) begin
            lk_err_q <= timeout;
        end else if (state_q == RESP && state_nxt != RESP) begin
            lk_err_q <= 1'b0;
        end
    end

    assign bus.lk_err = lk_err_q;
`else
    assign timeout    = 1'b0;
    assign bus.lk_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; lk_start only matters in IDLE
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.lk_start)    state_nxt = COLLECT;
            COLLECT: if (beat_q == 2'd3)  state_nxt = MEM;
            MEM:     if (done)            state_nxt = RESP;
            RESP:    if (beat_q == 2'd3)  state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // FSM outputs: capture strobes, completion, and next values of registered outputs
    always_comb begin
        done    = 1'b0;
        cap_en  = 1'b0;
        cap_idx = beat_q;
        case (state_q)
            IDLE: begin
                cap_en  = bus.lk_start;
                cap_idx = 2'd0;
            end
            COLLECT: cap_en = 1'b1;
            MEM:     done   = bus.mem_ready || timeout;
            default: ;
        endcase
        mem_we_nxt = (state_nxt == MEM) &&  frame_q.rw;
        mem_re_nxt = (state_nxt == MEM) && !frame_q.rw;
        rvalid_nxt = (state_nxt == RESP);
    end

    // Word returned to the link: all ones on timeout, zero for writes, else read data
    always_comb begin
        resp_word = 32'h0000_0000;
        if (timeout) begin
            resp_word = 32'hFFFF_FFFF;
        end else if (!frame_q.rw) begin
            resp_word = bus.mem_rdata;
        end
    end

    // Beat counter: 1..3 through COLLECT, 0..3 through RESP, held at 0 in MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= 2'd0;
        end else if (state_q == IDLE) begin
            beat_q <= bus.lk_start ? 2'd1 : 2'd0;
        end else if (state_q == COLLECT || state_q == RESP) begin
            beat_q <= beat_q + 2'd1;
        end
    end

    // Byte lane capture, LSB first; rw is taken only on the start beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
        end else if (cap_en) begin
            frame_q.addr[{cap_idx, 3'b000} +: 8]  <= bus.lk_addr;
            frame_q.wdata[{cap_idx, 3'b000} +: 8] <= bus.lk_wdata;
            if (state_q == IDLE) begin
                frame_q.rw <= bus.lk_rw;
            end
        end
    end

    // Memory request strobes are registered so they rise at S+4 and drop at R+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
        end else begin
            mem_we_q <= mem_we_nxt;
            mem_re_q <= mem_re_nxt;
        end
    end

    // Response serializer: byte 0 loads on completion, the rest shift out one per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_rdata_q  <= 8'h00;
            resp_sh_q   <= 24'h00_0000;
            lk_rvalid_q <= 1'b0;
        end else begin
            lk_rvalid_q <= rvalid_nxt;
            if (done) begin
                lk_rdata_q <= resp_word[7:0];
                resp_sh_q  <= resp_word[31:8];
            end else if (state_q == RESP) begin
                lk_rdata_q <= (state_nxt == RESP) ? resp_sh_q[7:0] : 8'h00;
                resp_sh_q  <= {8'h00, resp_sh_q[23:8]};
            end
        end
    end

    // Sticky flag for a frame start that arrived while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_overrun_q <= 1'b0;
        end else if (bus.lk_start && state_q != IDLE) begin
            lk_overrun_q <= 1'b1;
        end
    end

    assign bus.lk_rdata   = lk_rdata_q;
    assign bus.lk_rvalid  = lk_rvalid_q;
    assign bus.lk_overrun = lk_overrun_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_addr   = frame_q.addr[ADDR_W-1:0];
    assign bus.mem_wdata  = frame_q.wdata;

endmodule

// File: tb/tb_bytelink_mem_target.sv
// Purpose: scoreboard bench for bytelink_mem_target; stimulus queues expected memory requests and response bytes.
// Latency: expectations carry the exact cycle each request/response beat must appear in.
// Backpressure: memory waits are modelled by holding mem_ready low for a chosen number of cycles.
module tb_bytelink_mem_target;

    localparam int TMO = 4;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          first;
        int          len;
    } mreq_t;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         cyc;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errors;
    int   checks;
    bit   ovr_sticky;

    mreq_t mreq_q[$];
    rsp_t  rsp_q[$];
    bit    in_req;

    bytelink_mem_target_if #(.ADDR_W(32)) bus ();

    bytelink_mem_target #(
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: inside cycle k the DUT shows what it registered at posedge k
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every valid beat must match the head of the scoreboard
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.lk_rvalid === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rvalid", 64'(bus.lk_rdata), 64'hFFFF_FFFF);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_data", 64'(bus.lk_rdata), 64'(e.data));
                    chk("rsp_err", 64'(bus.lk_err), 64'(e.err));
                    chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Memory monitor: request kind, address and data held steady, start cycle and length
    initial begin
        mreq_t cur;
        int    start;
        in_req = 1'b0;
        start  = 0;
        cur    = '{0, 32'h0, 32'h0, 0, 0};
        forever begin
            @(negedge clk);
            if ((bus.mem_we | bus.mem_re) === 1'b1) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    start  = cyc;
                    if (mreq_q.size() == 0) begin
                        chk("unexpected_mem_req", 64'(cyc), 64'hFFFF_FFFF);
                    end else begin
                        cur = mreq_q.pop_front();
                    end
                end
                chk("mem_we", 64'(bus.mem_we), 64'(cur.we));
                chk("mem_re", 64'(bus.mem_re), 64'(!cur.we));
                chk("mem_addr", 64'(bus.mem_addr), 64'(cur.addr));
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
            end else if (in_req) begin
                in_req = 1'b0;
                chk("mem_req_start", 64'(start), 64'(cur.first));
                chk("mem_req_len", 64'(cyc - start), 64'(cur.len));
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // One full frame. waits<0 means memory never answers (timeout expected).
    // ovr_beat>0 raises an extra lk_start on that beat; early_rdy holds mem_ready high outside MEM.
    task automatic do_frame(input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input int ovr_beat,
                            input bit early_rdy);
        int          s;
        int          r;
        int          len;
        bit          err;
        logic [31:0] word;
        @(posedge clk); #1;
        s = cyc;
        if (waits < 0) begin
            len  = TMO;
            err  = 1'b1;
            word = 32'hFFFF_FFFF;
        end else begin
            len  = waits + 1;
            err  = 1'b0;
            word = rw ? 32'h0000_0000 : rdata;
        end
        r = s + 4 + len - 1;
        mreq_q.push_back('{rw, addr, wdata, s + 4, len});
        for (int k = 0; k < 4; k++) begin
            rsp_q.push_back('{word[8*k +: 8], err, r + 1 + k});
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                chk("overrun_during_collect", 64'(bus.lk_overrun),
                    64'(ovr_sticky || (ovr_beat > 0 && k > ovr_beat)));
            end
            bus.lk_start  = (k == 0) || (k == ovr_beat);
            bus.lk_rw     = (k == 0) ? rw : ~rw;
            bus.lk_addr   = addr[8*k +: 8];
            bus.lk_wdata  = wdata[8*k +: 8];
            bus.mem_ready = early_rdy;
            bus.mem_rdata = 32'h5A5A_5A5A;
        end
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            bus.lk_start  = 1'b0;
            bus.lk_rw     = 1'b0;
            bus.lk_addr   = 8'h00;
            bus.lk_wdata  = 8'h00;
            bus.mem_ready = (waits >= 0 && c == waits);
            bus.mem_rdata = (waits >= 0 && c == waits) ? rdata : (32'h5A5A_5A5A ^ 32'(c));
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus.mem_ready = early_rdy;
            bus.mem_rdata = 32'h0000_0000;
        end
        if (ovr_beat > 0) ovr_sticky = 1'b1;
    endtask

    initial begin
        int s;
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        ovr_sticky = 1'b0;
        rst_n         = 1'b0;
        bus.lk_start  = 1'b0;
        bus.lk_rw     = 1'b0;
        bus.lk_addr   = 8'h00;
        bus.lk_wdata  = 8'h00;
        bus.mem_rdata = 32'h0000_0000;
        bus.mem_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_lk_rvalid", 64'(bus.lk_rvalid), 64'h0);
        chk("reset_lk_rdata", 64'(bus.lk_rdata), 64'h0);
        chk("reset_lk_err", 64'(bus.lk_err), 64'h0);
        chk("reset_lk_overrun", 64'(bus.lk_overrun), 64'h0);
        chk("reset_mem_we", 64'(bus.mem_we), 64'h0);
        chk("reset_mem_re", 64'(bus.mem_re), 64'h0);
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'h0);
        chk("reset_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Read, zero wait; mem_ready also high outside MEM and must be ignored
        do_frame(1'b0, 32'h1234_5678, 32'h1122_3344, 32'hCAFE_BABE, 0, 0, 1'b1);
        // Write, 3 wait states, started on the first IDLE cycle (back-to-back)
        do_frame(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1357_9BDF, 3, 0, 1'b0);
        chk("overrun_after_back_to_back", 64'(bus.lk_overrun), 64'h0);

        // Second lk_start at S+2 is ignored but flagged
        do_frame(1'b0, 32'hA5A5_0004, 32'h0000_0000, 32'h0F1E_2D3C, 1, 2, 1'b0);
        chk("overrun_sticky_after_frame", 64'(bus.lk_overrun), 64'h1);
        do_frame(1'b1, 32'h0000_0040, 32'h8765_4321, 32'h0, 2, 0, 1'b0);
        chk("overrun_still_sticky", 64'(bus.lk_overrun), 64'h1);

        // Reset while the read is waiting in MEM
        @(posedge clk); #1;
        s = cyc;
        mreq_q.push_back('{1'b0, 32'h0BAD_F00D, 32'h0000_0000, s + 4, 1});
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus.lk_start = (k == 0);
            bus.lk_rw    = 1'b0;
            bus.lk_addr  = 32'h0BAD_F00D >> (8 * k);
            bus.lk_wdata = 8'h00;
        end
        @(posedge clk); #1;
        bus.lk_start = 1'b0;
        bus.lk_addr  = 8'h00;
        chk("pre_reset_mem_re", 64'(bus.mem_re), 64'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midmem_reset_mem_re", 64'(bus.mem_re), 64'h0);
        chk("midmem_reset_lk_rvalid", 64'(bus.lk_rvalid), 64'h0);
        chk("midmem_reset_lk_overrun", 64'(bus.lk_overrun), 64'h0);
        chk("midmem_reset_mem_addr", 64'(bus.mem_addr), 64'h0);
        ovr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh frame after reset behaves like the first read
        do_frame(1'b0, 32'h1234_5678, 32'h1122_3344, 32'hCAFE_BABE, 0, 0, 1'b0);
        // Ready on the last cycle a timeout build would still allow: a normal completion
        do_frame(1'b0, 32'h0000_0100, 32'h0000_0000, 32'h89AB_CDEF, TMO - 1, 0, 1'b0);
`ifdef BYTELINK_TIMEOUT_EN
        // Memory never answers: request held TMO cycles, then an error response
        do_frame(1'b0, 32'h0000_0200, 32'h0000_0000, 32'h0, -1, 0, 1'b0);
        do_frame(1'b1, 32'h0000_0300, 32'h0246_8ACE, 32'h0, 1, 0, 1'b0);
`endif

        repeat (8) @(posedge clk);
        #1;
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
        chk("mreq_queue_drained", 64'(mreq_q.size()), 64'h0);
        chk("mem_idle_at_end", 64'(in_req), 64'h0);
        chk("overrun_clear_at_end", 64'(bus.lk_overrun), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
